dev_reshuffler_tile: RTL and testbench

DEV_RESHUFFLER_TILE -- requirements
Module: dev_reshuffler_tile

---
 rtl/dev_reshuffler_tile.sv | 171 +++++++++++++++++
 tb/tb_dev_reshuffler_tile.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dev_reshuffler_tile.sv
// Lane reshuffler tile: per-beat pass or lane reverse, or SpatPar x SpatPar block transpose.
// All outputs come from registers; only the streaming ready term looks at z_ready_i.
module dev_reshuffler_tile #(
    parameter int unsigned SpatPar   = 8,
    parameter int unsigned DataWidth = 64
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [SpatPar*DataWidth-1:0]   a_i,
    input  logic                           a_valid_i,
    output logic                           a_ready_o,
    output logic [SpatPar*DataWidth-1:0]   z_o,
    output logic                           z_valid_o,
    input  logic                           z_ready_i,
    input  logic [1:0]                     mode_i,
    output logic                           busy_o,
    output logic [31:0]                    blk_cnt_o
);

    localparam int unsigned IdxW  = $clog2(SpatPar);
    localparam int unsigned BeatW = SpatPar * DataWidth;

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StStream = 2'd1;
    localparam logic [1:0] StFill   = 2'd2;
    localparam logic [1:0] StDrain  = 2'd3;

    localparam logic [1:0] ModeTranspose = 2'b01;
    localparam logic [1:0] ModeReverse   = 2'b10;

    localparam logic [IdxW-1:0] LastIdx = IdxW'(SpatPar - 1);

    logic [1:0]           state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [IdxW-1:0]      wr_idx_q, wr_idx_d;
    logic [IdxW-1:0]      rd_idx_q, rd_idx_d;
    logic [31:0]          blk_cnt_q, blk_cnt_d;
    logic                 z_valid_q, z_valid_d;
    logic [BeatW-1:0]     z_q;
    logic [BeatW-1:0]     col;
    logic [DataWidth-1:0] tile_q [SpatPar][SpatPar];

    logic       a_hs, z_hs;
    logic       fill_we, stream_we;
    logic [1:0] cur_mode;

    function automatic logic [BeatW-1:0] shuffle(input logic [BeatW-1:0] d,
                                                 input logic [1:0]       m);
        logic [BeatW-1:0] r;
        r = d;
        if (m == ModeReverse) begin
            for (int i = 0; i < SpatPar; i++) begin
                r[i*DataWidth +: DataWidth] = d[(SpatPar-1-i)*DataWidth +: DataWidth];
            end
        end
        return r;
    endfunction

    always_comb begin
        a_ready_o = 1'b0;
        if (!rst_i) begin
            case (state_q)
                StIdle:   a_ready_o = 1'b1;
                StStream: a_ready_o = !z_valid_q || z_ready_i;
                StFill:   a_ready_o = 1'b1;
                default:  a_ready_o = 1'b0;
            endcase
        end
    end

    assign z_valid_o = (state_q == StDrain) || z_valid_q;
    assign busy_o    = (state_q != StIdle);
    assign blk_cnt_o = blk_cnt_q;

    assign a_hs     = a_valid_i && a_ready_o;
    assign z_hs     = z_valid_o && z_ready_i;
    // Mode is only sampled from the port on the block's first handshake.
    assign cur_mode = (state_q == StIdle) ? mode_i : mode_q;

    assign fill_we   = a_hs && ((state_q == StFill) ||
                                (state_q == StIdle && mode_i == ModeTranspose));
    assign stream_we = a_hs && !fill_we;

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        blk_cnt_d = blk_cnt_q;
        z_valid_d = z_valid_q;
        case (state_q)
            StIdle: begin
                if (a_hs) begin
                    mode_d = mode_i;
                    if (mode_i == ModeTranspose) begin
                        state_d  = StFill;
                        wr_idx_d = IdxW'(1);
                    end else begin
                        state_d   = StStream;
                        z_valid_d = 1'b1;
                    end
                end
            end
            StStream: begin
                if (a_hs) begin
                    z_valid_d = 1'b1;
                end else if (z_hs) begin
                    z_valid_d = 1'b0;
                    state_d   = StIdle;
                end
            end
            StFill: begin
                if (a_hs) begin
                    wr_idx_d = wr_idx_q + 1'b1;
                    if (wr_idx_q == LastIdx) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (z_hs) begin
                    rd_idx_d = rd_idx_q + 1'b1;
                    if (rd_idx_q == LastIdx) begin
                        state_d   = StIdle;
                        blk_cnt_d = blk_cnt_q + 32'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            mode_q    <= 2'b00;
            wr_idx_q  <= '0;
            rd_idx_q  <= '0;
            blk_cnt_q <= '0;
            z_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            wr_idx_q  <= wr_idx_d;
            rd_idx_q  <= rd_idx_d;
            blk_cnt_q <= blk_cnt_d;
            z_valid_q <= z_valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (stream_we) begin
            z_q <= shuffle(a_i, cur_mode);
        end
        if (fill_we) begin
            for (int c = 0; c < SpatPar; c++) begin
                tile_q[wr_idx_q][c] <= a_i[c*DataWidth +: DataWidth];
            end
        end
    end

    always_comb begin
        col = '0;
        for (int i = 0; i < SpatPar; i++) begin
            col[i*DataWidth +: DataWidth] = tile_q[i][rd_idx_q];
        end
    end

    assign z_o = (state_q == StDrain) ? col : z_q;

endmodule

// File: tb/tb_dev_reshuffler_tile.sv
// Scoreboard bench for dev_reshuffler_tile (SpatPar=4, DataWidth=8): directed beats,
// expected beats queued by stimulus, popped by a monitor on each output handshake.
module tb_dev_reshuffler_tile;

    localparam int SP = 4;
    localparam int DW = 8;
    localparam int W  = SP * DW;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [W-1:0]  a_i = '0;
    logic          a_valid_i = 1'b0;
    logic          a_ready_o;
    logic [W-1:0]  z_o;
    logic          z_valid_o;
    logic          z_ready_i = 1'b1;
    logic [1:0]    mode_i = 2'b00;
    logic          busy_o;
    logic [31:0]   blk_cnt_o;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] sb[$];
    logic [W-1:0] mon_exp;
    logic [W-1:0] held_z;
    logic         held_v = 1'b0;

    dev_reshuffler_tile #(
        .SpatPar   (SP),
        .DataWidth (DW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .a_i       (a_i),
        .a_valid_i (a_valid_i),
        .a_ready_o (a_ready_o),
        .z_o       (z_o),
        .z_valid_o (z_valid_o),
        .z_ready_i (z_ready_i),
        .mode_i    (mode_i),
        .busy_o    (busy_o),
        .blk_cnt_o (blk_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs only change 1-2 time units after posedge, so negedge sees what the next edge sees.
    always @(negedge clk) begin
        if (!rst_i && z_valid_o) begin
            if (held_v) check("z_stable", z_o, held_z);
            if (z_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL z_unexpected: got %h want no beat", z_o);
                end else begin
                    mon_exp = sb.pop_front();
                    check("z_data", z_o, mon_exp);
                end
                held_v = 1'b0;
            end else begin
                held_v = 1'b1;
                held_z = z_o;
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic [1:0] m, output int waits);
        a_i       = d;
        a_valid_i = 1'b1;
        mode_i    = m;
        waits     = 0;
        forever begin
            @(negedge clk);
            if (a_ready_o) break;
            waits++;
            if (waits > 100) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got no a_ready want handshake");
                break;
            end
        end
        @(posedge clk);
        #1;
        a_valid_i = 1'b0;
    endtask

    task automatic drain_wait(input bit rnd, input bit in_drain);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0 && !z_valid_o) begin
                z_ready_i = 1'b1;
                return;
            end
            if (in_drain && sb.size() != 0) check("a_ready_drain", a_ready_o, 0);
            if (rnd) z_ready_i = 1'($urandom_range(0, 1));
        end
        z_ready_i = 1'b1;
        checks++;
        failures++;
        $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ready", a_ready_o, 0);
        check("rst_z_valid", z_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_blk_cnt", blk_cnt_o, 0);
        rst_i = 1'b0;
        #1;
        check("post_rst_a_ready", a_ready_o, 1);
    endtask

    task automatic run_block(input logic [W-1:0] b0, input logic [W-1:0] b1,
                             input logic [W-1:0] b2, input logic [W-1:0] b3,
                             input logic [1:0] m1, input bit rnd);
        int w;
        logic [W-1:0] beats [SP];
        logic [W-1:0] e;
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        for (int j = 0; j < SP; j++) begin
            for (int i = 0; i < SP; i++) e[i*DW +: DW] = beats[i][j*DW +: DW];
            sb.push_back(e);
        end
        send(b0, 2'b01, w);
        for (int r = 1; r < SP; r++) begin
            send(beats[r], m1, w);
            check("fill_no_stall", w, 0);
        end
        check("drain_first_valid", z_valid_o, 1);
        check("drain_a_ready", a_ready_o, 0);
        drain_wait(rnd, 1'b1);
    endtask

    initial begin
        int w;
        int total;

        do_reset();
        check("idle_busy", busy_o, 0);

        // Pass mode, back-to-back beats, one-cycle latency.
        total = 0;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(32'h04030201);
            send(32'h04030201, 2'b00, w);
            total += w;
            if (k == 0) begin
                check("pass_lat_valid", z_valid_o, 1);
                check("pass_lat_data", z_o, 32'h04030201);
                check("pass_busy", busy_o, 1);
            end
        end
        check("pass_one_per_cycle", total, 0);
        drain_wait(1'b0, 1'b0);
        check("pass_idle", busy_o, 0);

        sb.push_back(32'h01020304);
        send(32'h04030201, 2'b10, w);
        drain_wait(1'b0, 1'b0);

        sb.push_back(32'hAABBCCDD);
        send(32'hAABBCCDD, 2'b11, w);
        drain_wait(1'b0, 1'b0);

        // Transpose, ready held high.
        check("blk_cnt_before", blk_cnt_o, 0);
        run_block(32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130, 2'b01, 1'b0);
        check("blk_cnt_after", blk_cnt_o, 1);

        // Transpose with random backpressure and mode_i wiggling mid-block.
        run_block(32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0, 32'hD3D2D1D0, 2'b10, 1'b1);
        check("blk_cnt_rand", blk_cnt_o, 2);

        // Stream stall: register full, downstream blocked for 3 cycles.
        z_ready_i = 1'b0;
        sb.push_back(32'h11223344);
        sb.push_back(32'h55667788);
        send(32'h11223344, 2'b00, w);
        a_i       = 32'h55667788;
        a_valid_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_a_ready", a_ready_o, 0);
            check("stall_z_held", z_o, 32'h11223344);
        end
        @(posedge clk);
        #1;
        z_ready_i = 1'b1;
        send(32'h55667788, 2'b00, w);
        check("stall_release_hs", w, 0);
        drain_wait(1'b0, 1'b0);

        // Reset part-way through a fill; the partial block must vanish.
        send(32'hEEEEEEEE, 2'b01, w);
        send(32'hFFFFFFFF, 2'b01, w);
        do_reset();
        run_block(32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130, 2'b01, 1'b0);
        check("blk_cnt_post_rst", blk_cnt_o, 1);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
